// File: rtl/data_mem_ctrl.sv
// RV32IM data-memory controller: byte/half/word load/store, configurable wait states, one-cycle response pulse.
// Define DMEM_ERR_EN to report misaligned/illegal requests via rsp_err instead of aligning them down.
module data_mem_ctrl #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] LP_WAIT_LAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              r_ready;
    logic [3:0]        r_wait_cnt;
    logic              r_we;
    logic [2:0]        r_f3;
    logic [IDX_W+1:0]  r_addr;
    logic [31:0]       r_wdata;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_err;
    logic [31:0]       r_mem [DEPTH];

    logic              w_accept;
    logic              w_access;
    logic              w_wait_done;
    logic [IDX_W-1:0]  w_idx;
    logic [31:0]       w_word;
    logic              w_illegal;
    logic [1:0]        w_size;
    logic [1:0]        w_lane;
    logic              w_err;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata_lane;
    logic              w_mem_we;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;
    logic [31:0]       w_rsp_data;
    logic              w_unused_addr;

    // Upper address bits wrap modulo DEPTH*4.
    assign w_unused_addr = ^req_addr[31:IDX_W+2];
    assign w_wait_done   = (r_wait_cnt == LP_WAIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid && r_ready) begin
                    w_accept = 1'b1;
                    if (WAIT_STATES > 0) begin
                        w_state_nxt = WAIT;
                    end else begin
                        w_state_nxt = ACCESS;
                    end
                end
            end
            WAIT: begin
                if (w_wait_done) begin
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                w_access    = 1'b1;
                w_state_nxt = RESP;
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready     <= 1'b0;
            r_wait_cnt  <= '0;
            r_we        <= 1'b0;
            r_f3        <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_ready     <= (w_state_nxt == IDLE);
            r_rsp_valid <= w_access;
            if (r_state == WAIT && !w_wait_done) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_accept) begin
                r_we    <= req_we;
                r_f3    <= req_funct3;
                r_addr  <= req_addr[IDX_W+1:0];
                r_wdata <= req_wdata;
            end
            if (w_access) begin
                r_rsp_rdata <= w_rsp_data;
                r_rsp_err   <= w_err;
            end
        end
    end

    assign w_idx  = r_addr[IDX_W+1:2];
    assign w_word = r_mem[w_idx];

    always_comb begin
        w_illegal = (r_f3 == 3'b011) || (r_f3[2] && r_f3[1]) || (r_we && r_f3[2]);
        // Illegal funct3 falls back to a word access; in the error build it is flagged anyway.
        w_size = w_illegal ? 2'd2 : r_f3[1:0];
        w_lane = r_addr[1:0];
`ifdef DMEM_ERR_EN
        w_err = w_illegal
             || (w_size == 2'd1 && r_addr[0])
             || (w_size == 2'd2 && r_addr[1:0] != 2'b00);
`else
        w_err = 1'b0;
        if (w_size == 2'd1) begin
            w_lane[0] = 1'b0;
        end else if (w_size == 2'd2) begin
            w_lane = 2'b00;
        end
`endif
    end

    always_comb begin
        w_be         = 4'b1111;
        w_wdata_lane = r_wdata;
        case (w_size)
            2'd0: begin
                w_be         = 4'b0001 << w_lane;
                w_wdata_lane = {4{r_wdata[7:0]}};
            end
            2'd1: begin
                w_be         = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata_lane = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be         = 4'b1111;
                w_wdata_lane = r_wdata;
            end
        endcase
    end

    assign w_mem_we = w_access && r_we && !w_err;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_lane[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        case (w_lane)
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
        w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];
        case (w_size)
            2'd0:    w_load = {{24{~r_f3[2] & w_byte[7]}}, w_byte};
            2'd1:    w_load = {{16{~r_f3[2] & w_half[15]}}, w_half};
            default: w_load = w_word;
        endcase
        w_rsp_data = (r_we || w_err) ? '0 : w_load;
    end

    assign req_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: table of load/store vectors on a zero-wait instance,
// plus hand sequences for wait-state timing, reset abort and address aliasing.
module tb_data_mem_ctrl;

`ifdef DMEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        v0, we0, rdy0, rv0, er0;
    logic [2:0]  f30;
    logic [31:0] a0, wd0, rd0;
    logic        v3, we3, rdy3, rv3, er3;
    logic [2:0]  f33;
    logic [31:0] a3, wd3, rd3;

    data_mem_ctrl #(.DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v0), .req_ready(rdy0), .req_we(we0), .req_funct3(f30),
        .req_addr(a0), .req_wdata(wd0),
        .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(er0)
    );

    data_mem_ctrl #(.DEPTH(1024), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(v3), .req_ready(rdy3), .req_we(we3), .req_funct3(f33),
        .req_addr(a3), .req_wdata(wd3),
        .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(er3)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr, wdata, exp_rd,
                       input logic exp_err);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.exp_rd = exp_rd; v.exp_err = exp_err;
        tbl.push_back(v);
    endtask

    task automatic drive(input int sel, input logic v, we, input logic [2:0] f3, input logic [31:0] a, wd);
        if (sel == 0) begin
            v0 = v; we0 = we; f30 = f3; a0 = a; wd0 = wd;
        end else begin
            v3 = v; we3 = we; f33 = f3; a3 = a; wd3 = wd;
        end
    endtask

    function automatic logic rdy_of(input int sel);
        return (sel == 0) ? rdy0 : rdy3;
    endfunction
    function automatic logic rv_of(input int sel);
        return (sel == 0) ? rv0 : rv3;
    endfunction

    // One complete transaction, called and returning on a falling edge.
    task automatic do_req(input int sel, input string nm, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, wd, exp_rd, input logic exp_err);
        int n;
        int lat_exp;
        logic [31:0] r;
        lat_exp = (sel == 0) ? 2 : 5;
        n = 0;
        while (!rdy_of(sel) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, ".ready"}, 32'(rdy_of(sel)), 32'd1);
        drive(sel, 1'b1, we, f3, a, wd);
        @(posedge clk);
        @(negedge clk);
        r = $urandom;
        drive(sel, 1'b0, r[0], r[3:1], $urandom, $urandom);
        n = 1;
        while (!rv_of(sel) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, ".latency"}, 32'(n), 32'(lat_exp));
        chk({nm, ".rdata"}, (sel == 0) ? rd0 : rd3, exp_rd);
        chk({nm, ".err"}, 32'((sel == 0) ? er0 : er3), 32'(exp_err));
        @(negedge clk);
        chk({nm, ".pulse"}, 32'(rv_of(sel)), 32'd0);
        chk({nm, ".ready_back"}, 32'(rdy_of(sel)), 32'd1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(3, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        chk("rst.ready0", 32'(rdy0), 32'd0);
        chk("rst.rsp_valid0", 32'(rv0), 32'd0);
        chk("rst.rdata0", rd0, 32'h0);
        chk("rst.err0", 32'(er0), 32'd0);
        chk("rst.ready3", 32'(rdy3), 32'd0);
        rst_n = 1'b1;
        chk("rst.ready_at_release", 32'(rdy0), 32'd0);
        @(negedge clk);
        chk("rst.ready0_rise", 32'(rdy0), 32'd1);
        chk("rst.ready3_rise", 32'(rdy3), 32'd1);

        add(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        add(0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        add(1, 3'b000, 32'h13, 32'h12345680, 32'h0, 0);
        add(0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 0);
        add(0, 3'b100, 32'h13, 32'h0, 32'h00000080, 0);
        add(0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 0);
        add(0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFEF, 0);
        add(0, 3'b100, 32'h11, 32'h0, 32'h000000BE, 0);
        add(0, 3'b001, 32'h12, 32'h0, 32'hFFFF80AD, 0);
        add(0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 0);
        add(1, 3'b010, 32'h20, 32'h12345678, 32'h0, 0);
        add(1, 3'b001, 32'h22, 32'hAAAA8001, 32'h0, 0);
        add(0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 0);
        add(0, 3'b101, 32'h22, 32'h0, 32'h00008001, 0);
        add(0, 3'b010, 32'h20, 32'h0, 32'h80015678, 0);
        add(0, 3'b000, 32'h21, 32'h0, 32'h00000056, 0);
        add(0, 3'b100, 32'h23, 32'h0, 32'h00000080, 0);
        add(0, 3'b001, 32'h20, 32'h0, 32'h00005678, 0);
        add(1, 3'b010, 32'h11, 32'hCAFEF00D, 32'h0, ERR_EN);
        add(0, 3'b010, 32'h10, 32'h0, ERR_EN ? 32'h80ADBEEF : 32'hCAFEF00D, 0);
        add(0, 3'b001, 32'h21, 32'h0, ERR_EN ? 32'h0 : 32'h00005678, ERR_EN);
        add(0, 3'b010, 32'h22, 32'h0, ERR_EN ? 32'h0 : 32'h80015678, ERR_EN);
        add(0, 3'b011, 32'h20, 32'h0, ERR_EN ? 32'h0 : 32'h80015678, ERR_EN);
        add(1, 3'b010, 32'h30, 32'h0BADF00D, 32'h0, 0);
        add(1, 3'b100, 32'h30, 32'h11223344, 32'h0, ERR_EN);
        add(0, 3'b010, 32'h30, 32'h0, ERR_EN ? 32'h0BADF00D : 32'h11223344, 0);
        add(1, 3'b000, 32'h1021, 32'h0000003C, 32'h0, 0);
        add(0, 3'b010, 32'h20, 32'h0, 32'h80013C78, 0);
        add(0, 3'b010, 32'h1010, 32'h0, ERR_EN ? 32'h80ADBEEF : 32'hCAFEF00D, 0);
        add(1, 3'b001, 32'h33, 32'h0000BEEF, 32'h0, ERR_EN);
        add(0, 3'b010, 32'h30, 32'h0, ERR_EN ? 32'h0BADF00D : 32'hBEEF3344, 0);
        add(0, 3'b110, 32'h30, 32'h0, ERR_EN ? 32'h0 : 32'hBEEF3344, ERR_EN);

        foreach (tbl[i]) begin
            do_req(0, $sformatf("vec%0d", i), tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
                   tbl[i].exp_rd, tbl[i].exp_err);
        end

        // Three wait states: ready stays low through RESP while a second request is held pending.
        do_req(3, "w3.sw10", 1, 3'b010, 32'h10, 32'hA5A55A5A, 32'h0, 0);
        do_req(3, "w3.sw14", 1, 3'b010, 32'h14, 32'h01020304, 32'h0, 0);
        drive(3, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) drive(3, 1'b1, 1'b0, 3'b010, 32'h14, 32'h0);
            chk($sformatf("w3.ready_c%0d", k), 32'(rdy3), 32'(k == 6));
            chk($sformatf("w3.valid_c%0d", k), 32'(rv3), 32'(k == 5));
            if (k == 5) chk("w3.rdata1", rd3, 32'hA5A55A5A);
        end
        @(posedge clk);
        @(negedge clk);
        drive(3, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        n = 1;
        while (!rv3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("w3.held_latency", 32'(n), 32'd5);
        chk("w3.rdata2", rd3, 32'h01020304);
        @(negedge clk);

        // Reset during ACCESS (dut0) and WAIT (dut3): stores are dropped, no response.
        do_req(0, "abort.pre", 1, 3'b010, 32'h40, 32'h11111111, 32'h0, 0);
        drive(0, 1'b1, 1'b1, 3'b010, 32'h1040, 32'h22222222);
        drive(3, 1'b1, 1'b1, 3'b010, 32'h10, 32'hFFFFFFFF);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(3, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("abort.rv0", 32'(rv0), 32'd0);
            chk("abort.rdy0", 32'(rdy0), 32'd0);
            chk("abort.rv3", 32'(rv3), 32'd0);
            chk("abort.rdy3", 32'(rdy3), 32'd0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort.no_rsp0", 32'(rv0), 32'd0);
            chk("abort.no_rsp3", 32'(rv3), 32'd0);
        end
        do_req(0, "abort.lw40", 0, 3'b010, 32'h40, 32'h0, 32'h11111111, 0);
        do_req(3, "abort.lw10", 0, 3'b010, 32'h10, 32'h0, 32'hA5A55A5A, 0);

        do_req(0, "alias.sw", 1, 3'b010, 32'h1040, 32'h22222222, 32'h0, 0);
        do_req(0, "alias.lw40", 0, 3'b010, 32'h40, 32'h0, 32'h22222222, 0);
        do_req(0, "alias.lw2040", 0, 3'b010, 32'h2040, 32'h0, 32'h22222222, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised data-memory controller for the RV32IM load/store path. Replaces the flat word-only data memory.
- Accepts one request at a time over a valid/ready handshake and supports byte, halfword and word accesses, with sign/zero extension on loads.
- Provides configurable wait states and a registered one-cycle response pulse.
- Sits between the EX/MEM pipeline stage and the write-back mux.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, ≥ 4.
- WAIT_STATES, 0, extra cycles inserted before the array access (0..15).
- IDX_W, $clog2(DEPTH), word-index width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle and able to accept.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores.
- rsp_err  out  1  access error, qualified by rsp_valid.

Behaviour:
- Reset is one clock, asynchronous and active-low (clk, rst_n).
- Reset values: state = IDLE, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0. Array contents are not reset.
- req_ready is registered. It rises on the first clk edge after rst_n deasserts and is 1 only in IDLE.
- Accept: req_valid && req_ready sampled at edge E0. All req_* fields are latched at that edge; the fields are don't-care afterwards.
- FSM states: IDLE, WAIT, ACCESS, RESP.
  - IDLE → WAIT on accept if WAIT_STATES > 0; otherwise IDLE → ACCESS.
  - WAIT counts WAIT_STATES cycles, then moves to ACCESS.
  - ACCESS lasts one cycle. The array read or write happens at the edge leaving ACCESS, and the state moves to RESP.
  - RESP: rsp_valid = 1 for exactly one cycle, with rsp_rdata and rsp_err stable. Then → IDLE; req_ready returns to 1 in the cycle after RESP.
- Latency: rsp_valid is high in cycle E0 + 2 + WAIT_STATES. Throughput is one access per 3 + WAIT_STATES cycles. There is no back-pressure on the response; the consumer must take it.
- Indexing: word index = addr[IDX_W+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- Stores, lane select by addr[1:0]:
  - SB writes wdata[7:0] to byte addr[1:0].
  - SH writes wdata[15:0] to halfword addr[1].
  - SW writes all 4 bytes.
  - Unselected bytes are unchanged (per-byte write enable).
  - A store response carries rsp_rdata = 0.
- Loads: extract the byte or halfword selected by addr[1:0].
  - B and H sign-extend from bit 7 / bit 15.
  - BU and HU zero-extend.
  - W returns the full word.
- Misaligned access: H/HU with addr[0] = 1, or W with addr[1:0] ≠ 0.
- Illegal funct3: 011, 110, 111, and stores with 100 or 101.
- Reset mid-operation aborts the transaction. A store not yet past the ACCESS edge is not committed, and no response is produced.

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined:
  - A misaligned or illegal request performs no array write.
  - Its response carries rsp_rdata = 0 and rsp_err = 1.
  - Latency is unchanged.
- Undefined:
  - rsp_err is tied to 0.
  - Misaligned addresses are aligned down to the access size: addr[0] cleared for H, addr[1:0] cleared for W.
  - Illegal funct3 is treated as word access (LW/SW).

Test Plan:
1. WAIT_STATES = 0: SW 0xDEADBEEF @0x10, then LW @0x10 → each rsp_valid pulses 2 cycles after accept; LW rsp_rdata = 0xDEADBEEF.
2. SB 0x80 @0x13, then LB @0x13 → 0xFFFFFF80; LBU @0x13 → 0x00000080; LW @0x10 → 0x80ADBEEF.
3. SH 0x8001 @0x22, then LH → 0xFFFF8001, LHU → 0x00008001; LW @0x20 shows the low half unchanged from prior contents.
4. WAIT_STATES = 3: LW accepted at cycle 5 → rsp_valid only at cycle 10; req_ready = 0 during cycles 6–10; a req_valid held during that window is not accepted until cycle 11.
5. DMEM_ERR_EN defined: SW @0x11 → rsp_err = 1, and a subsequent LW @0x10 returns the old value. Undefined: same SW writes @0x10, rsp_err = 0.
6. SW @0x40 accepted, rst_n asserted in the WAIT/ACCESS cycle → no rsp_valid, req_ready = 0 during reset; after release, LW @0x40 returns the old value. Address 0x1000 + 0x40 with DEPTH = 1024 aliases to 0x40.
